// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: widths, write-back control indices and
// load-type encodings.
package mips_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned LT_W       = 3;
   localparam int unsigned WB_CTRL_W  = 2;

   // Bit positions inside the 2-bit WB control field
   localparam int unsigned WB_REGWRITE = 0;
   localparam int unsigned WB_MEMTOREG = 1;

   typedef enum logic [LT_W-1:0] {
      LT_LW  = 3'b000,
      LT_LB  = 3'b001,
      LT_LBU = 3'b010,
      LT_LH  = 3'b011,
      LT_LHU = 3'b100
   } load_type_e;

   // Contents of the MEM/WB pipeline register
   typedef struct packed {
      logic                  valid;
      logic                  reg_write;
      logic [REG_ADDR_W-1:0] rd;
      logic [DATA_W-1:0]     rd_data;
      logic                  align_err;
   } wb_entry_t;

endpackage

// File: rtl/load_align.sv
// Big-endian load data alignment and extension; purely combinational.
module load_align
   import mips_pkg::*;
(
   input  logic [DATA_W-1:0] raw_data,
   input  logic [1:0]        off,
   input  logic [LT_W-1:0]   load_type,
   output logic [DATA_W-1:0] aligned_data,
   output logic              misalign
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = raw_data[31:24];
      case (off)
         2'd0:    byte_sel = raw_data[31:24];
         2'd1:    byte_sel = raw_data[23:16];
         2'd2:    byte_sel = raw_data[15:8];
         default: byte_sel = raw_data[7:0];
      endcase
      // Misaligned halfwords fall back to the half picked by off[1]
      half_sel = off[1] ? raw_data[15:0] : raw_data[31:16];
   end

   always_comb begin
      aligned_data = raw_data;
      misalign     = (off != 2'd0);
      case (load_type)
         LT_LB: begin
            aligned_data = {{24{byte_sel[7]}}, byte_sel};
            misalign     = 1'b0;
         end
         LT_LBU: begin
            aligned_data = {24'd0, byte_sel};
            misalign     = 1'b0;
         end
         LT_LH: begin
            aligned_data = {{16{half_sel[15]}}, half_sel};
            misalign     = off[0];
         end
         LT_LHU: begin
            aligned_data = {16'd0, half_sel};
            misalign     = off[0];
         end
         default: begin
            // LW and reserved encodings pass the word through
            aligned_data = raw_data;
            misalign     = (off != 2'd0);
         end
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back select; drives the register file
// write port and keeps a retired-instruction count.
module wb_stage
   import mips_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 32
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  STALL,
   input  logic                  FLUSH,
   input  logic                  MEM_valid,
   input  logic [WB_CTRL_W-1:0]  MEM_WB,
   input  logic [REG_ADDR_W-1:0] MEM_RD,
   input  logic [DATA_W-1:0]     MEM_ALU_result,
   input  logic [DATA_W-1:0]     MEM_Read_data,
   input  logic [LT_W-1:0]       MEM_LoadType,
   output logic                  WB_RegWrite,
   output logic [REG_ADDR_W-1:0] WB_RD,
   output logic [DATA_W-1:0]     WB_RD_DATA,
   output logic                  WB_valid,
   output logic                  ALIGN_ERR,
   output logic [CNT_W-1:0]      RETIRE_COUNT
);

   logic [DATA_W-1:0] aligned_load;
   logic              load_misalign;
   logic              mem_to_reg;
   logic              misalign;
   wb_entry_t         wb_q;
   wb_entry_t         wb_next;
   logic [CNT_W-1:0]  retire_q;

   load_align u_load_align (
      .raw_data     (MEM_Read_data),
      .off          (MEM_ALU_result[1:0]),
      .load_type    (MEM_LoadType),
      .aligned_data (aligned_load),
      .misalign     (load_misalign)
   );

   // Misalignment only matters for instructions that actually load
   assign mem_to_reg = MEM_WB[WB_MEMTOREG];
   assign misalign   = mem_to_reg & load_misalign;

   always_comb begin
      wb_next           = '0;
      wb_next.valid     = MEM_valid;
      wb_next.rd        = MEM_RD;
      wb_next.rd_data   = mem_to_reg ? aligned_load : MEM_ALU_result;
      wb_next.reg_write = MEM_valid & MEM_WB[WB_REGWRITE]
                          & (MEM_RD != '0) & ~misalign;
      wb_next.align_err = MEM_valid & mem_to_reg & misalign;
   end

   // FLUSH beats STALL; a flush keeps rd/data so only the enables drop
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         wb_q     <= '0;
         retire_q <= '0;
      end else if (FLUSH) begin
         wb_q.valid     <= 1'b0;
         wb_q.reg_write <= 1'b0;
         wb_q.align_err <= 1'b0;
      end else if (!STALL) begin
         wb_q <= wb_next;
         if (MEM_valid) begin
            retire_q <= retire_q + CNT_W'(1);
         end
      end
   end

   assign WB_RegWrite  = wb_q.reg_write;
   assign WB_RD        = wb_q.rd;
   assign WB_RD_DATA   = wb_q.rd_data;
   assign WB_valid     = wb_q.valid;
   assign ALIGN_ERR    = wb_q.align_err;
   assign RETIRE_COUNT = retire_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus randomized traffic against a
// rule-level reference model; a 4-bit counter instance covers wrap-around.
module tb_wb_stage;

   logic        CLK = 1'b0;
   logic        RESET, STALL, FLUSH, MEM_valid;
   logic [1:0]  MEM_WB;
   logic [4:0]  MEM_RD;
   logic [31:0] MEM_ALU_result, MEM_Read_data;
   logic [2:0]  MEM_LoadType;

   logic        WB_RegWrite, WB_valid, ALIGN_ERR;
   logic [4:0]  WB_RD;
   logic [31:0] WB_RD_DATA, RETIRE_COUNT;
   logic        WB_RegWrite4, WB_valid4, ALIGN_ERR4;
   logic [4:0]  WB_RD4;
   logic [31:0] WB_RD_DATA4;
   logic [3:0]  RETIRE_COUNT4;

   wb_stage #(.DATA_W(32), .CNT_W(32)) dut (
      .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
      .MEM_valid(MEM_valid), .MEM_WB(MEM_WB), .MEM_RD(MEM_RD),
      .MEM_ALU_result(MEM_ALU_result), .MEM_Read_data(MEM_Read_data),
      .MEM_LoadType(MEM_LoadType), .WB_RegWrite(WB_RegWrite), .WB_RD(WB_RD),
      .WB_RD_DATA(WB_RD_DATA), .WB_valid(WB_valid), .ALIGN_ERR(ALIGN_ERR),
      .RETIRE_COUNT(RETIRE_COUNT)
   );

   wb_stage #(.DATA_W(32), .CNT_W(4)) dut4 (
      .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
      .MEM_valid(MEM_valid), .MEM_WB(MEM_WB), .MEM_RD(MEM_RD),
      .MEM_ALU_result(MEM_ALU_result), .MEM_Read_data(MEM_Read_data),
      .MEM_LoadType(MEM_LoadType), .WB_RegWrite(WB_RegWrite4), .WB_RD(WB_RD4),
      .WB_RD_DATA(WB_RD_DATA4), .WB_valid(WB_valid4), .ALIGN_ERR(ALIGN_ERR4),
      .RETIRE_COUNT(RETIRE_COUNT4)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic        m_valid, m_rw, m_err, m_dk;
   logic [4:0]  m_rd;
   logic [31:0] m_data, m_cnt;
   logic [3:0]  m_cnt4;

   function automatic void ref_load(input logic [31:0] raw, input logic [1:0] off,
                                    input logic [2:0] lt, output logic [31:0] d,
                                    output logic mis, output logic known);
      logic [7:0]  b;
      logic [15:0] h;
      known = 1'b1;
      d     = raw;
      mis   = 1'b0;
      case (lt)
         3'd1, 3'd2: begin
            b = 8'(raw >> (8 * (3 - int'(off))));
            d = (lt == 3'd1) ? 32'($signed(b)) : 32'(b);
         end
         3'd3, 3'd4: begin
            mis = off[0];
            if (mis) begin
               known = 1'b0;
               d     = '0;
            end else begin
               h = 16'(raw >> (16 - 8 * int'(off)));
               d = (lt == 3'd3) ? 32'($signed(h)) : 32'(h);
            end
         end
         default: begin
            d   = raw;
            mis = (off != 2'd0);
         end
      endcase
   endfunction

   task automatic model_clear();
      m_valid = 0; m_rw = 0; m_err = 0; m_dk = 1;
      m_rd = '0; m_data = '0; m_cnt = '0; m_cnt4 = '0;
   endtask

   task automatic model_edge();
      logic [31:0] d;
      logic        mis, known, mis_eff;
      if (RESET) begin
         model_clear();
      end else if (FLUSH) begin
         m_valid = 0; m_rw = 0; m_err = 0;
      end else if (!STALL) begin
         ref_load(MEM_Read_data, MEM_ALU_result[1:0], MEM_LoadType, d, mis, known);
         mis_eff = MEM_WB[1] && mis;
         m_valid = MEM_valid;
         m_rd    = MEM_RD;
         m_data  = MEM_WB[1] ? d : MEM_ALU_result;
         m_dk    = MEM_WB[1] ? known : 1'b1;
         m_rw    = MEM_valid && MEM_WB[0] && (MEM_RD != 5'd0) && !mis_eff;
         m_err   = MEM_valid && MEM_WB[1] && mis;
         if (MEM_valid) begin
            m_cnt  = m_cnt + 32'd1;
            m_cnt4 = m_cnt4 + 4'd1;
         end
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] wb, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] rdata,
                        input logic [2:0] lt, input logic st, input logic fl);
      MEM_valid = v; MEM_WB = wb; MEM_RD = rd; MEM_ALU_result = alu;
      MEM_Read_data = rdata; MEM_LoadType = lt; STALL = st; FLUSH = fl;
   endtask

   task automatic test_reset();
      drive(1, 2'b01, 5'd3, 32'hDEAD_BEEF, 32'h0, 3'd0, 0, 0);
      tick();
      #3 RESET = 1'b1;
      #1;
      n_tests++;
      if ({WB_valid, WB_RegWrite, WB_RD, WB_RD_DATA, ALIGN_ERR, RETIRE_COUNT} !== '0 ||
          {WB_valid4, WB_RegWrite4, WB_RD4, WB_RD_DATA4, ALIGN_ERR4, RETIRE_COUNT4} !== '0) begin
         n_fail++;
         $display("FAIL reset_async: data=%h cnt=%0d rw=%b v=%b required all zero",
                  WB_RD_DATA, RETIRE_COUNT, WB_RegWrite, WB_valid);
      end
      model_clear();
      drive(0, 2'b01, 5'd7, 32'h1234_5678, 32'h0, 3'd0, 0, 0);
      @(negedge CLK) RESET = 1'b0;
      repeat (5) tick();
      n_tests++;
      if (RETIRE_COUNT !== 32'd0 || WB_valid !== 1'b0 || WB_RegWrite !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: cnt=%0d v=%b rw=%b required 0 0 0",
                  RETIRE_COUNT, WB_valid, WB_RegWrite);
      end
   endtask

   task automatic test_alu_write();
      drive(1, 2'b01, 5'd8, 32'h0000_0042, 32'hFFFF_FFFF, 3'd1, 0, 0);
      tick();
      n_tests++;
      if ({WB_valid, WB_RegWrite, WB_RD, WB_RD_DATA, ALIGN_ERR, RETIRE_COUNT} !==
          {1'b1, 1'b1, 5'd8, 32'h42, 1'b0, 32'd1}) begin
         n_fail++;
         $display("FAIL alu_write: v=%b rw=%b rd=%0d data=%h err=%b cnt=%0d required 1 1 8 00000042 0 1",
                  WB_valid, WB_RegWrite, WB_RD, WB_RD_DATA, ALIGN_ERR, RETIRE_COUNT);
      end
   endtask

   task automatic test_loads();
      logic [2:0]  lt  [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
      logic [1:0]  off [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
      logic [31:0] exp [4] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'h0000_7F01, 32'h0000_80FF};
      for (int i = 0; i < 4; i++) begin
         drive(1, 2'b11, 5'(10 + i), {30'h0400_0000, off[i]}, 32'h80FF_7F01, lt[i], 0, 0);
         tick();
         n_tests++;
         if (WB_RD_DATA !== exp[i] || WB_RegWrite !== 1'b1 || ALIGN_ERR !== 1'b0 ||
             WB_RD !== 5'(10 + i)) begin
            n_fail++;
            $display("FAIL load_%0d: data=%h rw=%b err=%b rd=%0d required %h 1 0 %0d",
                     i, WB_RD_DATA, WB_RegWrite, ALIGN_ERR, WB_RD, exp[i], 10 + i);
         end
      end
   endtask

   task automatic test_misalign();
      drive(1, 2'b11, 5'd4, 32'h0000_1002, 32'hCAFE_F00D, 3'd0, 0, 0);
      tick();
      n_tests++;
      if (WB_RegWrite !== 1'b0 || ALIGN_ERR !== 1'b1 || WB_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL misalign_lw: rw=%b err=%b v=%b required 0 1 1", WB_RegWrite, ALIGN_ERR, WB_valid);
      end
      drive(1, 2'b11, 5'd5, 32'h0000_1001, 32'hCAFE_F00D, 3'd3, 0, 0);
      tick();
      n_tests++;
      if (WB_RegWrite !== 1'b0 || ALIGN_ERR !== 1'b1) begin
         n_fail++;
         $display("FAIL misalign_lh: rw=%b err=%b required 0 1", WB_RegWrite, ALIGN_ERR);
      end
      // Odd ALU result on a non-load must not flag misalignment
      drive(1, 2'b01, 5'd6, 32'h0000_0003, 32'h0, 3'd3, 0, 0);
      tick();
      n_tests++;
      if (WB_RegWrite !== 1'b1 || ALIGN_ERR !== 1'b0 || WB_RD_DATA !== 32'h3) begin
         n_fail++;
         $display("FAIL alu_no_misalign: rw=%b err=%b data=%h required 1 0 00000003",
                  WB_RegWrite, ALIGN_ERR, WB_RD_DATA);
      end
      drive(1, 2'b01, 5'd0, 32'h0000_0077, 32'h0, 3'd0, 0, 0);
      tick();
      n_tests++;
      if (WB_RegWrite !== 1'b0 || WB_valid !== 1'b1 || ALIGN_ERR !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_zero: rw=%b v=%b err=%b required 0 1 0", WB_RegWrite, WB_valid, ALIGN_ERR);
      end
   endtask

   task automatic test_stall_flush();
      logic [31:0] cnt_hold;
      drive(1, 2'b01, 5'd9, 32'h0000_0055, 32'h0, 3'd0, 0, 0);
      tick();
      cnt_hold = m_cnt;
      for (int i = 0; i < 3; i++) begin
         drive(1, 2'b11, 5'(20 + i), 32'($urandom), 32'($urandom), 3'd1, 1, 0);
         tick();
         n_tests++;
         if ({WB_valid, WB_RegWrite, WB_RD, WB_RD_DATA, RETIRE_COUNT} !==
             {1'b1, 1'b1, 5'd9, 32'h55, cnt_hold}) begin
            n_fail++;
            $display("FAIL stall_hold_%0d: v=%b rw=%b rd=%0d data=%h cnt=%0d required 1 1 9 00000055 %0d",
                     i, WB_valid, WB_RegWrite, WB_RD, WB_RD_DATA, RETIRE_COUNT, cnt_hold);
         end
      end
      drive(1, 2'b01, 5'd30, 32'h0000_0099, 32'h0, 3'd0, 1, 1);
      tick();
      n_tests++;
      if ({WB_valid, WB_RegWrite, ALIGN_ERR, WB_RD, WB_RD_DATA, RETIRE_COUNT} !==
          {1'b0, 1'b0, 1'b0, 5'd9, 32'h55, cnt_hold}) begin
         n_fail++;
         $display("FAIL stall_flush: v=%b rw=%b err=%b rd=%0d data=%h cnt=%0d required 0 0 0 9 00000055 %0d",
                  WB_valid, WB_RegWrite, ALIGN_ERR, WB_RD, WB_RD_DATA, RETIRE_COUNT, cnt_hold);
      end
   endtask

   task automatic test_wrap();
      #3 RESET = 1'b1;
      model_clear();
      @(negedge CLK) RESET = 1'b0;
      for (int i = 0; i < 17; i++) begin
         drive(1, 2'b01, 5'd1, 32'(i), 32'h0, 3'd0, 0, 0);
         tick();
      end
      n_tests++;
      if (RETIRE_COUNT4 !== 4'd1 || RETIRE_COUNT !== 32'd17) begin
         n_fail++;
         $display("FAIL counter_wrap: cnt4=%0d cnt32=%0d required 1 17", RETIRE_COUNT4, RETIRE_COUNT);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 5'($urandom_range(0, 6)),
               32'($urandom), 32'($urandom), 3'($urandom),
               1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 7) == 0));
         tick();
         n_tests++;
         if ({WB_valid, WB_RegWrite, WB_RD, ALIGN_ERR, RETIRE_COUNT, RETIRE_COUNT4} !==
             {m_valid, m_rw, m_rd, m_err, m_cnt, m_cnt4} ||
             (m_dk && WB_RD_DATA !== m_data)) begin
            n_fail++;
            $display("FAIL random_%0d: v=%b rw=%b rd=%0d err=%b data=%h cnt=%0d cnt4=%0d required %b %b %0d %b %h %0d %0d",
                     i, WB_valid, WB_RegWrite, WB_RD, ALIGN_ERR, WB_RD_DATA, RETIRE_COUNT,
                     RETIRE_COUNT4, m_valid, m_rw, m_rd, m_err, m_data, m_cnt, m_cnt4);
         end
         if ($urandom_range(0, 39) == 0) begin
            #2 RESET = 1'b1;
            #1;
            n_tests++;
            if ({WB_valid, WB_RegWrite, WB_RD, WB_RD_DATA, ALIGN_ERR, RETIRE_COUNT} !== '0) begin
               n_fail++;
               $display("FAIL random_reset_%0d: v=%b rw=%b data=%h cnt=%0d required all zero",
                        i, WB_valid, WB_RegWrite, WB_RD_DATA, RETIRE_COUNT);
            end
            model_clear();
            @(negedge CLK) RESET = 1'b0;
         end
      end
   endtask

   initial begin
      RESET = 1'b1;
      drive(0, 2'b00, 5'd0, 32'h0, 32'h0, 3'd0, 0, 0);
      model_clear();
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      test_reset();
      test_alu_write();
      test_loads();
      test_misalign();
      test_stall_flush();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
